// File: rtl/imem_loader.sv
// Byte-serial instruction-memory programmer: one 32-bit word in, four big-endian byte writes out.
// Five cycles per word (one handshake cycle plus four write cycles); in_ready only in ACCEPT, the memory port is never stalled.
module imem_loader #(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] num_words,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold
);

    localparam int unsigned CW = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_WIDTH-1:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         remaining_q;
    logic [CW-1:0]         remaining_dec;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           word_q;
    logic [1:0]            byte_idx_q;
    logic                  start_ok;
    logic                  handshake;
    logic                  last_byte;

    assign start_ok      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign handshake     = (state_q == S_ACCEPT) && in_valid;
    assign last_byte     = (state_q == S_WRITE) && (byte_idx_q == 2'd3);
    assign remaining_dec = remaining_q - CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (num_words != '0) ? S_ACCEPT : S_DONE;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (byte_idx_q == 2'd3) begin
                    state_d = (remaining_dec == '0) ? S_DONE : S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath counters; the address keeps running across words so wrap is free modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            byte_idx_q  <= '0;
        end else begin
            if (start_ok) begin
                remaining_q <= num_words;
                addr_q      <= BASE_ALIGNED;
            end
            if (handshake) begin
                word_q     <= in_data;
                byte_idx_q <= 2'd0;
            end
            if (state_q == S_WRITE) begin
                addr_q     <= addr_q + ADDR_WIDTH'(1);
                byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (last_byte) begin
                remaining_q <= remaining_dec;
            end
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q;
                case (byte_idx_q)
                    2'd0:    mem_wdata = word_q[31:24];
                    2'd1:    mem_wdata = word_q[23:16];
                    2'd2:    mem_wdata = word_q[15:8];
                    default: mem_wdata = word_q[7:0];
                endcase
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        cpu_hold = busy;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0xFFFE) share stimulus; byte writes are scoreboarded.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] num_words = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready0, mem_we0, busy0, done0, cpu_hold0;
    logic [15:0] mem_addr0;
    logic [7:0]  mem_wdata0;
    logic        in_ready1, mem_we1, busy1, done1, cpu_hold1;
    logic [15:0] mem_addr1;
    logic [7:0]  mem_wdata1;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          t_start = 0;
    logic [15:0] exp_addr0, exp_addr1;
    logic [23:0] q0[$];
    logic [23:0] q1[$];
    logic [31:0] words[8];
    logic [7:0]  mem_model [0:65535];

    imem_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .busy(busy0), .done(done0), .cpu_hold(cpu_hold0)
    );

    imem_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'hFFFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1), .cpu_hold(cpu_hold1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every byte write must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (cpu_hold0 !== busy0 || (mem_we0 !== 1'b1 && (mem_addr0 !== 16'h0 || mem_wdata0 !== 8'h0))) begin
                miscompares++;
                $display("FAIL quiet_outputs: hold=%b busy=%b we=%b addr=%h data=%h, required hold==busy and addr/data zero when we=0",
                         cpu_hold0, busy0, mem_we0, mem_addr0, mem_wdata0);
            end
            if (mem_we0 === 1'b1) begin
                vectors++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL write0_unexpected: got addr=%h data=%h, required no write", mem_addr0, mem_wdata0);
                end else begin
                    logic [23:0] e;
                    e = q0.pop_front();
                    if ({mem_addr0, mem_wdata0} !== e) begin
                        miscompares++;
                        $display("FAIL write0: got addr=%h data=%h, required addr=%h data=%h", mem_addr0, mem_wdata0, e[23:8], e[7:0]);
                    end
                end
                mem_model[mem_addr0] = mem_wdata0;
            end
            if (mem_we1 === 1'b1) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL write1_unexpected: got addr=%h data=%h, required no write", mem_addr1, mem_wdata1);
                end else begin
                    logic [23:0] e;
                    e = q1.pop_front();
                    if ({mem_addr1, mem_wdata1} !== e) begin
                        miscompares++;
                        $display("FAIL write1: got addr=%h data=%h, required addr=%h data=%h", mem_addr1, mem_wdata1, e[23:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic push_bytes(input logic [31:0] w, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            q0.push_back({exp_addr0, w[31-8*b -: 8]});
            q1.push_back({exp_addr1, w[31-8*b -: 8]});
            exp_addr0 = exp_addr0 + 16'd1;
            exp_addr1 = exp_addr1 + 16'd1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; num_words = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q0.delete(); q1.delete();
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1 start = 1'b1;
        num_words = 15'(n);
        exp_addr0 = 16'h0000;
        exp_addr1 = 16'hFFFC;
        t_start = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic feed(input int first, input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            in_valid = 1'b1;
            in_data = words[first+i];
            do begin @(negedge clk); k++; end while (in_ready0 !== 1'b1 && k < 40);
            if (in_ready0 !== 1'b1) begin
                ok = 1'b0;
                in_valid = 1'b0;
                return;
            end
            push_bytes(words[first+i], 4);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int elapsed);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (done0 !== 1'b1 && k < 80);
        elapsed = (done0 === 1'b1) ? (cyc - t_start) : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({in_ready0, mem_we0, mem_addr0, mem_wdata0, busy0, done0, cpu_hold0} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b hold=%b, required all 0",
                     in_ready0, mem_we0, mem_addr0, mem_wdata0, busy0, done0, cpu_hold0);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || in_ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b rdy=%b, required 0 0 0", busy0, done0, in_ready0);
        end
    endtask

    task automatic test_load_two();
        bit ok;
        int el;
        words[0] = 32'h00500093;
        words[1] = 32'h00A00113;
        do_start(2);
        feed(0, 2, ok);
        wait_done(el);
        vectors++;
        if (!ok || el != 11) begin
            miscompares++;
            $display("FAIL load_two_latency: feed_ok=%0d cycles=%0d, required 1 and 11", ok, el);
        end
        vectors++;
        if (q0.size() != 0) begin
            miscompares++;
            $display("FAIL load_two_drain: %0d writes missing, required 0", q0.size());
        end
        vectors++;
        if ({mem_model[0], mem_model[1], mem_model[2], mem_model[3]} !== 32'h00500093) begin
            miscompares++;
            $display("FAIL fetch_pc0: got %h, required 00500093", {mem_model[0], mem_model[1], mem_model[2], mem_model[3]});
        end
        vectors++;
        if ({mem_model[4], mem_model[5], mem_model[6], mem_model[7]} !== 32'h00A00113) begin
            miscompares++;
            $display("FAIL fetch_pc4: got %h, required 00a00113", {mem_model[4], mem_model[5], mem_model[6], mem_model[7]});
        end
    endtask

    task automatic test_reset_midload();
        bit ok;
        int k;
        do_start(2);
        feed(0, 1, ok);
        in_valid = 1'b1;
        in_data = words[1];
        k = 0;
        do begin @(negedge clk); k++; end while (in_ready0 !== 1'b1 && k < 40);
        push_bytes(words[1], 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (!ok || {in_ready0, mem_we0, mem_addr0, mem_wdata0, busy0, done0, cpu_hold0} !== '0) begin
            miscompares++;
            $display("FAIL midload_reset: ok=%0d rdy=%b we=%b addr=%h data=%h busy=%b done=%b hold=%b, required all 0",
                     ok, in_ready0, mem_we0, mem_addr0, mem_wdata0, busy0, done0, cpu_hold0);
        end
        vectors++;
        if (q0.size() != 0) begin
            miscompares++;
            $display("FAIL midload_partial: %0d pre-reset writes missing, required 0", q0.size());
        end
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || in_ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_idle: busy=%b done=%b rdy=%b, required 0 0 0", busy0, done0, in_ready0);
        end
    endtask

    task automatic test_zero_len();
        do_start(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (done0 !== 1'b1 || busy0 !== 1'b0 || cpu_hold0 !== 1'b0 || in_ready0 !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_len[%0d]: done=%b busy=%b hold=%b rdy=%b, required 1 0 0 0", i, done0, busy0, cpu_hold0, in_ready0);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int el;
        words[2] = 32'hCAFEF00D;
        do_start(1);
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready0 !== 1'b1 || mem_we0 !== 1'b0 || busy0 !== 1'b1) begin
                miscompares++;
                $display("FAIL stall[%0d]: rdy=%b we=%b busy=%b, required 1 0 1", i, in_ready0, mem_we0, busy0);
            end
        end
        @(posedge clk); #1;
        feed(2, 1, ok);
        wait_done(el);
        vectors++;
        if (!ok || el != 13) begin
            miscompares++;
            $display("FAIL stall_latency: feed_ok=%0d cycles=%0d, required 1 and 13", ok, el);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int el;
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h01234567;
        do_start(2);
        feed(0, 2, ok);
        wait_done(el);
        vectors++;
        if (!ok || el != 11 || q1.size() != 0 || done1 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap: ok=%0d cycles=%0d pending=%0d done1=%b, required 1 11 0 1", ok, el, q1.size(), done1);
        end
    endtask

    task automatic test_start_busy();
        bit ok, ok2;
        int el;
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        words[2] = 32'h99AABBCC;
        do_start(2);
        feed(0, 1, ok);
        start = 1'b1;
        num_words = 15'd5;
        @(posedge clk);
        #1 start = 1'b0;
        feed(1, 1, ok2);
        wait_done(el);
        vectors++;
        if (!ok || !ok2 || el != 11) begin
            miscompares++;
            $display("FAIL start_busy: ok=%0d/%0d cycles=%0d, required 1/1 and 11", ok, ok2, el);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || q0.size() != 0) begin
            miscompares++;
            $display("FAIL start_busy_hold: done=%b busy=%b pending=%0d, required 1 0 0", done0, busy0, q0.size());
        end
        do_start(1);
        vectors++;
        if (done0 !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_from_done: done=%b busy=%b, required 0 1", done0, busy0);
        end
        feed(2, 1, ok);
        wait_done(el);
        vectors++;
        if (!ok || el != 6) begin
            miscompares++;
            $display("FAIL restart_latency: ok=%0d cycles=%0d, required 1 and 6", ok, el);
        end
    endtask

    task automatic test_start_valid_idle();
        int el;
        do_reset();
        @(posedge clk);
        #1 start = 1'b1;
        num_words = 15'd1;
        in_valid = 1'b1;
        in_data = 32'hA5B6C7D8;
        exp_addr0 = 16'h0000;
        exp_addr1 = 16'hFFFC;
        t_start = cyc;
        @(negedge clk);
        vectors++;
        if (in_ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: rdy=%b, required 0", in_ready0);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready0 !== 1'b1 || mem_we0 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_not_consumed: rdy=%b we=%b, required 1 0", in_ready0, mem_we0);
        end
        push_bytes(32'hA5B6C7D8, 4);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(el);
        vectors++;
        if (el != 6 || q0.size() != 0) begin
            miscompares++;
            $display("FAIL idle_handshake: cycles=%0d pending=%0d, required 6 and 0", el, q0.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_two();
        test_reset_midload();
        test_zero_len();
        test_stall();
        test_wrap();
        test_start_busy();
        test_start_valid_idle();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
